// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and helpers for the memory-port arbiter.
//   - state_e : arbiter FSM states (idle / burst in progress)
//   - grant_e : which cache owns the memory port
//   - idx_w() : word-index width for a block of a given word count
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Memory words are 32-bit, so the two lowest byte-address bits are always 0.
  localparam int BYTE_OFF_W = 2;

  function automatic int idx_w(input int block_words);
    return $clog2(block_words);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Combinational 2-way round-robin picker between the I-cache and D-cache.
//   A lone requester always wins; under contention the side that did not
//   win last time is picked.
// Ports
//   req_i      in  I-cache requesting
//   req_d      in  D-cache requesting
//   last_grant in  side that completed the most recent burst
//   gnt_i      out pick the I-cache
//   gnt_d      out pick the D-cache
// ---------------------------------------------------------------------------
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   gnt_i,
  output logic   gnt_d
);

  assign gnt_d = req_d && (!req_i || (last_grant == GNT_I));
  assign gnt_i = req_i && (!req_d || (last_grant == GNT_D));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one main-memory port between I-cache refills and D-cache
//   refills/write-backs. Each grant runs a full BLOCK_WORDS-word burst;
//   contention is resolved round-robin so neither cache can starve.
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   ic_req/ic_addr                   I-cache refill request and block address
//   ic_rdata/ic_rvalid/ic_word/ic_done  I-cache refill beat interface
//   dc_req/dc_we/dc_addr/dc_wdata    D-cache request, direction, address, data
//   dc_rdata/dc_rvalid/dc_word/dc_done  D-cache beat interface
//   mem_req/mem_we/mem_addr/mem_wdata   memory command side
//   mem_rdata/mem_ack                memory response side (ack may stall)
//   busy                             burst in progress
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int IDX_W      = idx_w(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  // I-cache side
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic [IDX_W-1:0]  ic_word,
  output logic              ic_done,
  // D-cache side
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic [IDX_W-1:0]  dc_word,
  output logic              dc_done,
  // Memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int OFF = IDX_W + BYTE_OFF_W;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

  state_e                  state_q;
  grant_e                  gnt_q;
  grant_e                  last_grant_q;
  logic                    we_q;
  logic [ADDR_W-OFF-1:0]   blk_q;
  logic [IDX_W-1:0]        word_q;

  logic pick_i;
  logic pick_d;
  logic in_burst;
  logic beat;
  logic final_beat;
  logic is_i;
  logic is_d;

  // Offset bits of the incoming addresses are deliberately discarded: every
  // burst starts at word 0 of the block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[OFF-1:0], dc_addr[OFF-1:0]};

  rr_arbiter2 u_rr (
    .req_i     (ic_req),
    .req_d     (dc_req),
    .last_grant(last_grant_q),
    .gnt_i     (pick_i),
    .gnt_d     (pick_d)
  );

  assign in_burst   = (state_q == ST_BURST);
  assign beat       = in_burst && mem_ack;   // mem_ack in IDLE is ignored
  assign final_beat = beat && (word_q == LAST_WORD);
  assign is_i       = in_burst && (gnt_q == GNT_I);
  assign is_d       = in_burst && (gnt_q == GNT_D);

  // The FSM only samples requests in IDLE. A requester drops its req at the
  // edge that leaves BURST, so the following IDLE cycle never re-grants it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_I;
      last_grant_q <= GNT_I;
      we_q         <= 1'b0;
      blk_q        <= '0;
      word_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          word_q <= '0;
          if (pick_d) begin
            gnt_q   <= GNT_D;
            we_q    <= dc_we;
            blk_q   <= dc_addr[ADDR_W-1:OFF];
            state_q <= ST_BURST;
          end else if (pick_i) begin
            gnt_q   <= GNT_I;
            we_q    <= 1'b0;
            blk_q   <= ic_addr[ADDR_W-1:OFF];
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (mem_ack) begin
            // Counter wraps to 0 naturally on the final beat.
            word_q <= word_q + IDX_W'(1);
            if (word_q == LAST_WORD) begin
              last_grant_q <= gnt_q;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory command side, all derived from registered state.
  assign busy      = in_burst;
  assign mem_req   = in_burst;
  assign mem_we    = in_burst && we_q;
  assign mem_addr  = in_burst ? {blk_q, word_q, 2'b00} : '0;
  assign mem_wdata = (is_d && we_q) ? dc_wdata : '0;

  // Beat returns: read data passes straight through, qualified by the grant.
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign ic_rvalid = is_i && beat;
  assign dc_rvalid = is_d && beat && !we_q;
  assign ic_word   = is_i ? word_q : '0;
  assign dc_word   = is_d ? word_q : '0;
  assign ic_done   = is_i && final_beat;
  assign dc_done   = is_d && final_beat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter (BLOCK_WORDS = 4).
//   Inputs change on the falling edge; outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BW     = 4;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_rvalid;
  logic [IDX_W-1:0]  ic_word;
  logic              ic_done;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_rvalid;
  logic [IDX_W-1:0]  dc_word;
  logic              dc_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BLOCK_WORDS(BW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_rdata (ic_rdata),
    .ic_rvalid(ic_rvalid),
    .ic_word  (ic_word),
    .ic_done  (ic_done),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_rdata (dc_rdata),
    .dc_rvalid(dc_rvalid),
    .dc_word  (dc_word),
    .dc_done  (dc_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one burst starting at the next falling edge. The grant must already
  // have been taken at the rising edge in between. side_d selects which cache
  // is expected to own the port; stall inserts un-acked cycles before each beat.
  task automatic run_burst(input string tag, input bit side_d, input bit we,
                           input logic [31:0] base, input int stall);
    logic [31:0] rd;
    for (int k = 0; k < BW; k++) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (side_d && we) dc_wdata = 32'hC0DE_0000 + 32'(dc_word);
        #1;
        check(tag, "stall_req",    32'(mem_req),   32'd1);
        check(tag, "stall_addr",   mem_addr,       base + 32'(4 * k));
        check(tag, "stall_rvalid", 32'(ic_rvalid | dc_rvalid), 32'd0);
        check(tag, "stall_done",   32'(ic_done | dc_done),     32'd0);
        if (side_d && we) check(tag, "stall_wdata", mem_wdata, 32'hC0DE_0000 + 32'(k));
      end
      @(negedge clk);
      rd        = 32'hA0 + 32'(k) + (side_d ? 32'h100 : 32'h0);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      if (side_d && we) dc_wdata = 32'hC0DE_0000 + 32'(dc_word);
      #1;
      check(tag, "busy",     32'(busy),    32'd1);
      check(tag, "mem_req",  32'(mem_req), 32'd1);
      check(tag, "mem_we",   32'(mem_we),  32'(we));
      check(tag, "mem_addr", mem_addr,     base + 32'(4 * k));
      if (side_d) begin
        check(tag, "dc_word",   32'(dc_word),   32'(k));
        check(tag, "ic_word",   32'(ic_word),   32'd0);
        check(tag, "dc_rvalid", 32'(dc_rvalid), 32'(!we));
        check(tag, "ic_rvalid", 32'(ic_rvalid), 32'd0);
        check(tag, "dc_done",   32'(dc_done),   32'(k == BW - 1));
        check(tag, "ic_done",   32'(ic_done),   32'd0);
        if (!we) check(tag, "dc_rdata",  dc_rdata,  rd);
        else     check(tag, "mem_wdata", mem_wdata, 32'hC0DE_0000 + 32'(k));
      end else begin
        check(tag, "ic_word",   32'(ic_word),   32'(k));
        check(tag, "dc_word",   32'(dc_word),   32'd0);
        check(tag, "ic_rvalid", 32'(ic_rvalid), 32'd1);
        check(tag, "dc_rvalid", 32'(dc_rvalid), 32'd0);
        check(tag, "ic_done",   32'(ic_done),   32'(k == BW - 1));
        check(tag, "dc_done",   32'(dc_done),   32'd0);
        check(tag, "ic_rdata",  ic_rdata,       rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst", "mem_req",  32'(mem_req),  32'd0);
    check("rst", "busy",     32'(busy),     32'd0);
    check("rst", "mem_we",   32'(mem_we),   32'd0);
    check("rst", "mem_addr", mem_addr,      32'd0);
    check("rst", "rvalid",   32'(ic_rvalid | dc_rvalid), 32'd0);
    check("rst", "done",     32'(ic_done | dc_done),     32'd0);
    reset = 1'b0;

    // 1: single I-cache refill at 0x40, ack every cycle.
    @(negedge clk);
    ic_req  = 1'b1;
    ic_addr = 32'h40;
    #1;
    check("t1", "req_latency", 32'(mem_req), 32'd0);
    run_burst("t1", 1'b0, 1'b0, 32'h40, 0);
    @(negedge clk);
    ic_req  = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("t1", "idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("t1", "no_regrant", 32'(busy), 32'd0);

    // 2+3: contention from reset, both held for four bursts -> D,I,D,I,
    // each separated by exactly one idle cycle.
    do_reset();
    @(negedge clk);
    ic_req  = 1'b1;
    ic_addr = 32'h40;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h200;
    #1;
    check("t2", "req_latency", 32'(mem_req), 32'd0);
    for (int b = 0; b < 4; b++) begin
      run_burst($sformatf("t3_b%0d", b), (b % 2) == 0, 1'b0,
                ((b % 2) == 0) ? 32'h200 : 32'h40, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      if (b == 3) begin
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
      #1;
      check($sformatf("t3_b%0d", b), "dead_cycle", 32'(busy), 32'd0);
    end
    @(negedge clk);
    #1;
    check("t3", "no_regrant", 32'(busy), 32'd0);

    // 4: D-cache write-back at 0x100 with 3 stall cycles per word.
    @(negedge clk);
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 32'h100;
    run_burst("t4", 1'b1, 1'b1, 32'h100, 3);
    @(negedge clk);
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("t4", "idle_we", 32'(mem_we), 32'd0);

    // 5: reset after two acks of an I burst aborts it; a held request restarts at word 0.
    @(negedge clk);
    ic_req  = 1'b1;
    ic_addr = 32'h40;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'h55 + 32'(k);
      #1;
      check("t5", "pre_word", 32'(ic_word), 32'(k));
      check("t5", "pre_addr", mem_addr,     32'h40 + 32'(4 * k));
    end
    @(negedge clk);
    mem_ack = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5", "abort_req",  32'(mem_req), 32'd0);
    check("t5", "abort_busy", 32'(busy),    32'd0);
    run_burst("t5", 1'b0, 1'b0, 32'h40, 0);
    @(negedge clk);
    ic_req  = 1'b0;
    mem_ack = 1'b0;

    // 6: stray ack in IDLE does nothing; unaligned I address is block-aligned.
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("t6", "idle_rvalid", 32'(ic_rvalid | dc_rvalid), 32'd0);
    check("t6", "idle_done",   32'(ic_done | dc_done),     32'd0);
    check("t6", "idle_busy",   32'(busy),                  32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    ic_req  = 1'b1;
    ic_addr = 32'h4F;
    run_burst("t6", 1'b0, 1'b0, 32'h40, 1);
    @(negedge clk);
    ic_req  = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("t6", "end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
